// File: rtl/cnn_frame_sequencer_if.sv
// rtl/cnn_frame_sequencer_if.sv - handshake bundle between the frame sequencer and its environment
// Ports (slave = sequencer view):
//   in : start_signal, pixel_valid, pixel_in[7:0], feat_valid, fc_result_valid, fc_result_data[RES_W-1:0]
//   out: pixel_ready, fe_start, fe_pixel_valid, fe_pixel_data[7:0], fc_start, fc_done,
//        result_valid, result_data[RES_W-1:0], busy, frame_count[15:0], error
interface cnn_frame_sequencer_if #(
  parameter int RES_W = 48
);
  logic                    start_signal;
  logic                    pixel_valid;
  logic [7:0]              pixel_in;
  logic                    pixel_ready;
  logic                    fe_start;
  logic                    fe_pixel_valid;
  logic [7:0]              fe_pixel_data;
  logic                    feat_valid;
  logic                    fc_start;
  logic                    fc_result_valid;
  logic signed [RES_W-1:0] fc_result_data;
  logic                    fc_done;
  logic                    result_valid;
  logic signed [RES_W-1:0] result_data;
  logic                    busy;
  logic [15:0]             frame_count;
  logic                    error;

  modport slave (
    input  start_signal, pixel_valid, pixel_in, feat_valid, fc_result_valid, fc_result_data,
    output pixel_ready, fe_start, fe_pixel_valid, fe_pixel_data, fc_start, fc_done,
           result_valid, result_data, busy, frame_count, error
  );

  modport master (
    output start_signal, pixel_valid, pixel_in, feat_valid, fc_result_valid, fc_result_data,
    input  pixel_ready, fe_start, fe_pixel_valid, fe_pixel_data, fc_start, fc_done,
           result_valid, result_data, busy, frame_count, error
  );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// rtl/cnn_frame_sequencer.sv - per-frame sequencer: pixel stream -> feature extractor -> FC stage
// Ports:
//   clk           clock, all logic on posedge
//   rst           synchronous active-high reset
//   io_bus        cnn_frame_sequencer_if.slave (pixel in, feature extractor, FC and status signals)
// Optional feature: define CNN_SEQ_TIMEOUT_EN to enable the DRAIN/FC_RUN watchdog.
module cnn_frame_sequencer #(
  parameter int PIX_PER_FRAME  = 1024,
  parameter int FEAT_PER_FRAME = 225,
  parameter int RES_W          = 48,
  parameter int TIMEOUT_CYC    = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  cnn_frame_sequencer_if.slave   io_bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FC_RUN = 2'd3;

  localparam logic [15:0] LP_PIX_LAST  = 16'(PIX_PER_FRAME - 1);
  localparam logic [15:0] LP_FEAT_LAST = 16'(FEAT_PER_FRAME - 1);

  logic [1:0]              r_state;
  logic [15:0]             r_pix_cnt;
  logic [15:0]             r_feat_cnt;
  logic                    r_feat_done;   // feature count completed while pixels still streaming
  logic                    r_fe_start;
  logic                    r_fe_pix_valid;
  logic [7:0]              r_fe_pix_data;
  logic                    r_fc_start;
  logic                    r_fc_done;
  logic                    r_res_valid;
  logic signed [RES_W-1:0] r_res_data;
  logic [15:0]             r_frame_count;
  logic                    r_error;

  logic w_accept;
  logic w_feat_last;
  logic w_feats_complete;
  logic w_fcv_fall;

  assign w_accept         = (r_state == ST_STREAM) && io_bus.pixel_valid;
  assign w_feat_last      = (r_feat_cnt == LP_FEAT_LAST);
  // Features are complete if already latched, or if the final one arrives this very cycle.
  assign w_feats_complete = r_feat_done || (io_bus.feat_valid && w_feat_last);
  // r_res_valid doubles as last cycle's fc_result_valid.
  assign w_fcv_fall       = r_res_valid && !io_bus.fc_result_valid;

`ifdef CNN_SEQ_TIMEOUT_EN
  localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] r_wd_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYC;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_pix_cnt      <= '0;
      r_feat_cnt     <= '0;
      r_feat_done    <= 1'b0;
      r_fe_start     <= 1'b0;
      r_fe_pix_valid <= 1'b0;
      r_fe_pix_data  <= '0;
      r_fc_start     <= 1'b0;
      r_fc_done      <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_frame_count  <= '0;
      r_error        <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
      r_wd_cnt       <= '0;
`endif
    end else begin
      r_fe_start     <= 1'b0;
      r_fc_start     <= 1'b0;
      r_fc_done      <= 1'b0;
      r_fe_pix_valid <= w_accept;
      if (w_accept) begin
        r_fe_pix_data <= io_bus.pixel_in;
      end
      r_res_valid <= io_bus.fc_result_valid;
      r_res_data  <= io_bus.fc_result_data;

      case (r_state)
        ST_IDLE: begin
          if (io_bus.feat_valid) begin
            r_error <= 1'b1;
          end
          // Start wins over a stray feature in the same cycle: a new frame begins clean.
          if (io_bus.start_signal) begin
            r_state     <= ST_STREAM;
            r_fe_start  <= 1'b1;
            r_error     <= 1'b0;
            r_pix_cnt   <= '0;
            r_feat_cnt  <= '0;
            r_feat_done <= 1'b0;
          end
        end

        ST_STREAM: begin
          if (io_bus.feat_valid && !r_feat_done) begin
            if (w_feat_last) begin
              r_feat_done <= 1'b1;
              r_feat_cnt  <= '0;
            end else begin
              r_feat_cnt <= r_feat_cnt + 16'd1;
            end
          end
          if (w_accept) begin
            if (r_pix_cnt == LP_PIX_LAST) begin
              r_pix_cnt <= '0;
              if (w_feats_complete) begin
                r_state     <= ST_FC_RUN;
                r_fc_start  <= 1'b1;
                r_feat_cnt  <= '0;
                r_feat_done <= 1'b0;
              end else begin
                r_state <= ST_DRAIN;
              end
            end else begin
              r_pix_cnt <= r_pix_cnt + 16'd1;
            end
          end
        end

        ST_DRAIN: begin
          if (io_bus.feat_valid) begin
            if (w_feat_last) begin
              r_state    <= ST_FC_RUN;
              r_fc_start <= 1'b1;
              r_feat_cnt <= '0;
            end else begin
              r_feat_cnt <= r_feat_cnt + 16'd1;
            end
          end
        end

        ST_FC_RUN: begin
          if (io_bus.feat_valid) begin
            r_error <= 1'b1;
          end
          if (w_fcv_fall) begin
            r_fc_done     <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase

`ifdef CNN_SEQ_TIMEOUT_EN
      // Any upstream activity restarts the watchdog; expiry overrides the state update above.
      if ((r_state == ST_DRAIN) || (r_state == ST_FC_RUN)) begin
        if (io_bus.feat_valid || io_bus.fc_result_valid) begin
          r_wd_cnt <= '0;
        end else if (r_wd_cnt == LP_TO_LAST) begin
          r_wd_cnt   <= '0;
          r_error    <= 1'b1;
          r_fc_done  <= 1'b1;
          r_feat_cnt <= '0;
          r_state    <= ST_IDLE;
        end else begin
          r_wd_cnt <= r_wd_cnt + 32'd1;
        end
      end else begin
        r_wd_cnt <= '0;
      end
`endif
    end
  end

  assign io_bus.pixel_ready    = (r_state == ST_STREAM);
  assign io_bus.busy           = (r_state != ST_IDLE);
  assign io_bus.fe_start       = r_fe_start;
  assign io_bus.fe_pixel_valid = r_fe_pix_valid;
  assign io_bus.fe_pixel_data  = r_fe_pix_data;
  assign io_bus.fc_start       = r_fc_start;
  assign io_bus.fc_done        = r_fc_done;
  assign io_bus.result_valid   = r_res_valid;
  assign io_bus.result_data    = r_res_data;
  assign io_bus.frame_count    = r_frame_count;
  assign io_bus.error          = r_error;

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb/tb_cnn_frame_sequencer.sv - directed scoreboard bench for cnn_frame_sequencer
module tb_cnn_frame_sequencer;

  localparam int RES_W = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cnn_frame_sequencer_if #(.RES_W(RES_W)) ifc ();

  cnn_frame_sequencer #(
    .PIX_PER_FRAME (16),
    .FEAT_PER_FRAME(4),
    .RES_W         (RES_W),
    .TIMEOUT_CYC   (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_fcs   = 0;
  int n_fcd   = 0;

  logic [7:0]              pixq[$];
  logic signed [RES_W-1:0] resq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (ifc.fe_pixel_valid) begin
      if (pixq.size() == 0) chk("pix_unexpected", 1, 0);
      else                  chk("pix_scoreboard", ifc.fe_pixel_data, pixq.pop_front());
    end
    if (ifc.result_valid) begin
      if (resq.size() == 0) chk("res_unexpected", 1, 0);
      else                  chk("res_scoreboard", ifc.result_data, resq.pop_front());
    end
    if (ifc.fc_start) n_fcs++;
    if (ifc.fc_done)  n_fcd++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    ifc.start_signal = 1'b1;
    tick();
    ifc.start_signal = 1'b0;
    chk("fe_start_pulse", ifc.fe_start, 1);
    chk("busy_after_start", ifc.busy, 1);
    chk("ready_in_stream", ifc.pixel_ready, 1);
    chk("error_cleared_on_start", ifc.error, 0);
    tick();
    chk("fe_start_one_cycle", ifc.fe_start, 0);
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic f);
    ifc.pixel_in    = d;
    ifc.pixel_valid = 1'b1;
    ifc.feat_valid  = f;
    if (ifc.pixel_ready) pixq.push_back(d);
    tick();
    ifc.pixel_valid = 1'b0;
    ifc.feat_valid  = 1'b0;
    chk("fe_pixel_valid_lat1", ifc.fe_pixel_valid, 1);
    chk("fe_pixel_data_lat1", ifc.fe_pixel_data, d);
  endtask

  task automatic gap();
    tick();
    chk("fe_pixel_valid_gap", ifc.fe_pixel_valid, 0);
  endtask

  task automatic feat();
    ifc.feat_valid = 1'b1;
    tick();
    ifc.feat_valid = 1'b0;
  endtask

  task automatic fc_result(input logic signed [RES_W-1:0] d);
    ifc.fc_result_valid = 1'b1;
    ifc.fc_result_data  = d;
    resq.push_back(d);
    tick();
    ifc.fc_result_valid = 1'b0;
    chk("result_valid_lat1", ifc.result_valid, 1);
  endtask

  task automatic full_stream(input logic [7:0] base);
    for (int i = 0; i < 16; i++) send_pixel(base + 8'(i), 1'b0);
    chk("ready_low_after_last", ifc.pixel_ready, 0);
    for (int i = 0; i < 3; i++) feat();
    chk("no_fc_start_early", ifc.fc_start, 0);
    feat();
    chk("fc_start_on_last_feat", ifc.fc_start, 1);
  endtask

  int s0, d0;

  initial begin
    ifc.start_signal    = 1'b0;
    ifc.pixel_valid     = 1'b0;
    ifc.pixel_in        = '0;
    ifc.feat_valid      = 1'b0;
    ifc.fc_result_valid = 1'b0;
    ifc.fc_result_data  = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_pixel_ready", ifc.pixel_ready, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_fe_start", ifc.fe_start, 0);
    chk("rst_fe_pixel_valid", ifc.fe_pixel_valid, 0);
    chk("rst_fc_start", ifc.fc_start, 0);
    chk("rst_fc_done", ifc.fc_done, 0);
    chk("rst_result_valid", ifc.result_valid, 0);
    chk("rst_frame_count", ifc.frame_count, 0);
    chk("rst_error", ifc.error, 0);
    rst = 1'b0;
    tick();

    // Nominal frame with gaps in pixel_valid and a stray start mid-stream.
    start_frame();
    s0 = n_fcs;
    d0 = n_fcd;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) ifc.start_signal = 1'b1;
      send_pixel(8'(i), 1'b0);
      ifc.start_signal = 1'b0;
      if (i == 5) chk("start_ignored_in_stream", ifc.fe_start, 0);
      if (i % 3 == 1) gap();
    end
    chk("ready_low_after_16", ifc.pixel_ready, 0);
    chk("busy_in_drain", ifc.busy, 1);
    for (int i = 0; i < 3; i++) feat();
    chk("no_fc_start_3feat", ifc.fc_start, 0);
    feat();
    chk("fc_start_4th_feat", ifc.fc_start, 1);
    tick();
    chk("fc_start_one_cycle", ifc.fc_start, 0);
    fc_result(-48'sd5);
    chk("result_data_neg5", ifc.result_data, -64'sd5);
    tick();
    chk("fc_done_pulse", ifc.fc_done, 1);
    chk("frame_count_1", ifc.frame_count, 1);
    chk("idle_after_done", ifc.busy, 0);
    chk("error_clean", ifc.error, 0);
    tick();
    chk("fc_done_one_cycle", ifc.fc_done, 0);
    chk("one_fc_start", n_fcs - s0, 1);
    chk("one_fc_done", n_fcd - d0, 1);

    // Early features: all four arrive before pixel 16.
    start_frame();
    for (int i = 0; i < 15; i++) send_pixel(8'h40 + 8'(i), (i inside {2, 4, 6, 8}));
    chk("early_no_fc_start", ifc.fc_start, 0);
    chk("early_still_ready", ifc.pixel_ready, 1);
    send_pixel(8'h4F, 1'b0);
    chk("early_fc_start_after_last", ifc.fc_start, 1);
    chk("early_ready_low", ifc.pixel_ready, 0);
    ifc.fc_result_valid = 1'b1;
    ifc.fc_result_data  = 48'sh7FFF_FFFF_FFFF;
    resq.push_back(48'sh7FFF_FFFF_FFFF);
    tick();
    ifc.fc_result_data = 48'sh0000_0000_00A5;
    resq.push_back(48'sh0000_0000_00A5);
    tick();
    chk("no_done_while_valid", ifc.fc_done, 0);
    ifc.fc_result_valid = 1'b0;
    ifc.start_signal    = 1'b1;
    tick();
    ifc.start_signal = 1'b0;
    chk("early_fc_done", ifc.fc_done, 1);
    chk("frame_count_2", ifc.frame_count, 2);
    tick();
    chk("start_on_done_ignored_busy", ifc.busy, 0);
    chk("start_on_done_ignored_fe", ifc.fe_start, 0);

    // Error path: extra feature in FC_RUN, sticky until next start.
    start_frame();
    full_stream(8'hA0);
    feat();
    chk("error_set_fc_run", ifc.error, 1);
    chk("state_unchanged_busy", ifc.busy, 1);
    fc_result(48'sh123);
    tick();
    chk("err_frame_done", ifc.fc_done, 1);
    chk("frame_count_3", ifc.frame_count, 3);
    chk("error_sticky", ifc.error, 1);
    feat();
    chk("error_idle_feat", ifc.error, 1);
    chk("idle_feat_stays_idle", ifc.busy, 0);
    start_frame();

    // Reset mid-stream at pixel 7.
    for (int i = 0; i < 7; i++) send_pixel(8'h10 + 8'(i), 1'b0);
    rst             = 1'b1;
    ifc.pixel_valid = 1'b1;
    ifc.pixel_in    = 8'h17;
    tick();
    ifc.pixel_valid = 1'b0;
    chk("midrst_fe_pixel_valid", ifc.fe_pixel_valid, 0);
    chk("midrst_fe_pixel_data", ifc.fe_pixel_data, 0);
    chk("midrst_ready", ifc.pixel_ready, 0);
    chk("midrst_busy", ifc.busy, 0);
    chk("midrst_frame_count", ifc.frame_count, 0);
    chk("midrst_error", ifc.error, 0);
    chk("midrst_fc_done", ifc.fc_done, 0);
    s0 = n_fcs;
    d0 = n_fcd;
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_no_fc_done", n_fcd - d0, 0);
    chk("midrst_no_fc_start", n_fcs - s0, 0);
    start_frame();
    full_stream(8'hC0);
    tick();
    fc_result(48'sh8000_0000_0000);
    tick();
    chk("post_rst_fc_done", ifc.fc_done, 1);
    chk("post_rst_frame_count", ifc.frame_count, 1);
    chk("post_rst_error", ifc.error, 0);

`ifdef CNN_SEQ_TIMEOUT_EN
    start_frame();
    full_stream(8'hE0);
    repeat (31) tick();
    chk("to_not_yet_busy", ifc.busy, 1);
    chk("to_not_yet_error", ifc.error, 0);
    tick();
    chk("to_fc_done", ifc.fc_done, 1);
    chk("to_error", ifc.error, 1);
    chk("to_idle", ifc.busy, 0);
    chk("to_frame_count", ifc.frame_count, 1);
`endif

    tick();
    tick();
    chk("pix_queue_drained", pixq.size(), 0);
    chk("res_queue_drained", resq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_frame_sequencer.md
CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

Interface
REQ-001 SHALL have parameter PIX_PER_FRAME, default 1024, giving the pixels accepted per frame (range 2..65535).
REQ-002 SHALL have parameter FEAT_PER_FRAME, default 225, giving the feature results expected per frame, i.e. the flatten depth (range 1..65535).
REQ-003 SHALL have parameter RES_W, default 48, giving the signed result width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096, giving the watchdog limit in cycles.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start_signal  in  1  frame start request.
REQ-008 pixel_valid  in  1  upstream pixel strobe.
REQ-009 pixel_in  in  8  upstream pixel.
REQ-010 pixel_ready  out  1  pixel accept.
REQ-011 fe_start  out  1  one-cycle start pulse to the feature extractor.
REQ-012 fe_pixel_valid  out  1  registered pixel strobe to the feature extractor.
REQ-013 fe_pixel_data  out  8  registered pixel to the feature extractor.
REQ-014 feat_valid  in  1  feature result strobe from the feature extractor.
REQ-015 fc_start  out  1  one-cycle FC start pulse.
REQ-016 fc_result_valid  in  1  FC result strobe.
REQ-017 fc_result_data  in  RES_W  FC result, signed.
REQ-018 fc_done  out  1  one-cycle pulse that releases the flatten buffer.
REQ-019 result_valid  out  1  registered copy of the FC result strobe.
REQ-020 result_data  out  RES_W  registered copy of the FC result, signed.
REQ-021 busy  out  1  high in every state other than IDLE.
REQ-022 frame_count  out  16  count of completed frames, wraps at 0xFFFF to 0.
REQ-023 error  out  1  sticky error flag.

Function
REQ-024 SHALL implement the states IDLE, STREAM, DRAIN and FC_RUN.
REQ-025 IDLE->STREAM SHALL occur on start_signal; fe_start SHALL pulse for one cycle in the cycle after start_signal; the same start_signal SHALL clear error.
REQ-026 start_signal SHALL be ignored outside IDLE.
REQ-027 pixel_ready SHALL be 1 only in STREAM.
REQ-028 An accepted pixel (pixel_valid and pixel_ready) SHALL appear on fe_pixel_valid and fe_pixel_data exactly 1 cycle later; fe_pixel_valid SHALL otherwise be 0.
REQ-029 A 16-bit pixel counter SHALL count accepted pixels; the PIX_PER_FRAME-th accept SHALL move STREAM->DRAIN and clear the pixel counter.
REQ-030 A 16-bit feature counter SHALL count feat_valid in STREAM and DRAIN.
REQ-031 When the FEAT_PER_FRAME-th feature arrives in DRAIN, or in STREAM after the last pixel, the block SHALL pulse fc_start for one cycle, move to FC_RUN and clear the feature counter.
REQ-032 If the feature count completes before the last pixel, the block SHALL finish accepting pixels, then go straight to FC_RUN with fc_start in the cycle after the last accept.
REQ-033 feat_valid in FC_RUN or IDLE SHALL set error; the state SHALL be unchanged.
REQ-034 result_valid and result_data SHALL be fc_result_valid and fc_result_data registered 1 cycle, in every state.
REQ-035 In FC_RUN, a falling edge of fc_result_valid (high last cycle, low now) SHALL pulse fc_done for one cycle, increment frame_count and move to IDLE, all in the same clock edge.
REQ-036 start_signal in the same cycle as the fc_done edge SHALL be ignored; a new frame needs start_signal in IDLE.
REQ-037 Counters SHALL be sized to 16 bits; no arithmetic is performed on the result data, which SHALL pass through bit-exact.

Reset
REQ-038 On rst the block SHALL enter IDLE and clear all counters.
REQ-039 On rst all outputs SHALL be 0, including error and frame_count.
REQ-040 rst mid-frame SHALL abort the frame without issuing fc_done or fc_start.

Configuration
REQ-041 With macro CNN_SEQ_TIMEOUT_EN defined, a cycle counter SHALL run in DRAIN and FC_RUN and be cleared on every feat_valid or fc_result_valid.
REQ-042 With CNN_SEQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC the block SHALL set error, pulse fc_done and return to IDLE without incrementing frame_count.
REQ-043 Without CNN_SEQ_TIMEOUT_EN, the block SHALL have no watchdog and SHALL wait indefinitely in DRAIN and FC_RUN.

Verification (PIX_PER_FRAME=16, FEAT_PER_FRAME=4, TIMEOUT_CYC=32)
REQ-044 Nominal frame: start, 16 pixels, 4 feat_valid in DRAIN, fc_result_valid for 1 cycle with data -5 -> one fc_start, result_data=-5, one fc_done, frame_count=1, error=0.
REQ-045 Pixel pass-through: pixels 0x00..0x0F with gaps in pixel_valid -> fe_pixel_data reproduces the same sequence, each 1 cycle after accept; pixel_ready=0 after the 16th accept.
REQ-046 Early features: 4 feat_valid arrive before pixel 16 -> fc_start in the cycle after the 16th accept.
REQ-047 Error path: extra feat_valid in FC_RUN -> error=1, which clears on the next start_signal.
REQ-048 Reset mid-STREAM at pixel 7 -> all outputs 0, no fc_done; a following frame completes normally with frame_count=1.
REQ-049 Timeout (macro defined): no fc_result_valid for 32 cycles in FC_RUN -> error=1, fc_done pulse, state IDLE, frame_count unchanged.
